uart_frame_ctrl: RTL and testbench
==================================

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 The block SHALL have a parameter MAX_LEN, default 16, giving the maximum payload bytes per frame (range 1..255).
REQ-002 The block SHALL have a parameter HDR_BYTE, default 8'hA5, giving the frame start marker.
REQ-003 The block SHALL have a parameter TIMEOUT_CYCLES, default 1000000, giving the maximum clk cycles allowed between bytes inside a frame.
REQ-004 Ports SHALL be as follows, one per line:
  clk  input  1  single system clock; all logic on rising edge.
  rst_n  input  1  asynchronous, active-low reset.
  rx_done  input  1  one-cycle strobe: rx_data holds a new received byte.
  rx_data  input  8  received byte, valid when rx_done=1.
  rd_addr  input  clog2(MAX_LEN)  payload buffer read index.
  rd_data  output  8  payload byte at rd_addr, registered.
  frame_ready  output  1  level: a complete, checked frame is held in the buffer.
  frame_len  output  8  payload length of the held frame.
  frame_ack  input  1  consumer releases the held frame.
  len_err  output  1  one-cycle pulse: illegal length byte.
  chk_err  output  1  one-cycle pulse: checksum mismatch.
  overrun_err  output  1  one-cycle pulse: byte dropped while a frame is held.
  timeout_err  output  1  one-cycle pulse: inter-byte timeout.

Function
REQ-005 The frame format SHALL be HDR_BYTE, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-006 The FSM SHALL have states IDLE, LEN, PAYLOAD, CHK, HOLD; only rx_done=1 cycles advance it, except for frame_ack and timeout.
REQ-007 In IDLE, a byte equal to HDR_BYTE SHALL move to LEN; any other byte SHALL be ignored silently.
REQ-008 In LEN, a byte of 0 or greater than MAX_LEN SHALL pulse len_err and return to IDLE; otherwise the byte SHALL be latched, the running XOR SHALL be set to it, byte_cnt SHALL be cleared, and the FSM SHALL go to PAYLOAD.
REQ-009 In PAYLOAD, each byte SHALL be written to buffer[byte_cnt] and XORed into the running checksum, and byte_cnt SHALL increment; after the LEN-th byte the FSM SHALL go to CHK.
REQ-010 In CHK, a byte equal to the running XOR SHALL move to HOLD; a mismatch SHALL pulse chk_err and return to IDLE.
REQ-011 frame_ready SHALL be 1 exactly while in HOLD, asserting the cycle after the CHK rx_done; frame_len SHALL equal the latched LEN while in HOLD.
REQ-012 In HOLD, the buffer and frame_len SHALL be frozen, and each rx_done without frame_ack SHALL pulse overrun_err and discard the byte.
REQ-013 frame_ack=1 in HOLD SHALL move to IDLE the next cycle; an rx_done in the same cycle SHALL be evaluated as an IDLE byte (HDR_BYTE moves to LEN) with no overrun_err.
REQ-014 frame_ack outside HOLD SHALL be ignored.
REQ-015 rd_data SHALL present buffer[rd_addr] one cycle after rd_addr; it is valid for indices below frame_len in HOLD, and other values are don't-care.
REQ-016 All error pulses SHALL last exactly one cycle, occur the cycle after the offending rx_done, and are mutually exclusive.

Reset
REQ-017 rst_n=0 SHALL asynchronously force IDLE, byte_cnt=0, checksum=0, frame_len=0, frame_ready=0, rd_data=0, all error pulses=0 and timeout count=0; buffer contents are not reset.
REQ-018 Reset asserted mid-frame SHALL abandon the frame with no error pulse; the first frame after release SHALL be received normally.

Configuration
REQ-019 With macro UART_FRAME_TIMEOUT_EN defined, a counter SHALL clear on every rx_done and in IDLE/HOLD, and SHALL increment in LEN/PAYLOAD/CHK; reaching TIMEOUT_CYCLES SHALL pulse timeout_err and return to IDLE.
REQ-020 Without UART_FRAME_TIMEOUT_EN, no counter SHALL be built, timeout_err SHALL be tied to 0, and LEN/PAYLOAD/CHK SHALL wait indefinitely.

Verification
REQ-021 Bytes A5,03,11,22,33,03 -> frame_ready=1 the cycle after the last rx_done, frame_len=3, and rd_addr 0/1/2 read 11/22/33.
REQ-022 Bytes A5,02,10,20,31 (expected 32) -> chk_err pulse once, frame_ready stays 0, and the FSM is back in IDLE.
REQ-023 Bytes A5,00 and A5,11 (MAX_LEN=16) -> len_err pulse after each length byte, with no frame_ready.
REQ-024 Frame held plus byte 5A without ack -> overrun_err pulse and frame_len unchanged; then frame_ack together with rx_done A5 -> IDLE with the next state LEN and no overrun_err.
REQ-025 With UART_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=50: A5,04,01, then idle 50 cycles -> timeout_err pulse and IDLE; A5 followed by a complete valid frame then succeeds.
REQ-026 rst_n low for 1 cycle after A5,02,AA -> immediate IDLE with no error pulses; a following valid frame yields frame_ready=1.

Source files
------------

// File: rtl/uart_frame_ctrl_if.sv
// Frame controller bus: byte strobe in, held-frame status and buffer read port out.
// slave = frame controller, master = byte source / frame consumer.
interface uart_frame_ctrl_if #(
    parameter int MAX_LEN = 16
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic          rx_done;
    logic [7:0]    rx_data;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_ready;
    logic [7:0]    frame_len;
    logic          frame_ack;
    logic          len_err;
    logic          chk_err;
    logic          overrun_err;
    logic          timeout_err;

    modport slave (
        input  rx_done, rx_data, rd_addr, frame_ack,
        output rd_data, frame_ready, frame_len, len_err, chk_err, overrun_err, timeout_err
    );

    modport master (
        output rx_done, rx_data, rd_addr, frame_ack,
        input  rd_data, frame_ready, frame_len, len_err, chk_err, overrun_err, timeout_err
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// UART frame receiver: HDR, LEN, payload, XOR checksum; holds one frame until frame_ack.
// Errors/frame_ready one cycle after the rx_done; inter-byte timeout only with UART_FRAME_TIMEOUT_EN.
module uart_frame_ctrl #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] HDR_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_frame_ctrl_if.slave   bus
);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         DEPTH     = 1 << AW;
    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, HOLD} state_t;

    state_t     state, state_nxt;
    logic [7:0] byte_cnt, byte_cnt_nxt;
    logic [7:0] chk, chk_nxt;
    logic [7:0] len_q, len_nxt;
    logic       len_err_nxt, chk_err_nxt, ovr_nxt;
    logic       wr_en;
    logic       in_frame;
    logic [7:0] buffer [DEPTH];

    assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CHK);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          tmo_err_q;

    // The cycle the counter would reach TIMEOUT_CYCLES is the expiry cycle.
    assign tmo_hit = in_frame && !bus.rx_done && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_err_q <= tmo_hit;
            if (bus.rx_done || !in_frame) tmo_cnt <= '0;
            else                          tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign bus.timeout_err = tmo_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        chk_nxt      = chk;
        len_nxt      = len_q;
        len_err_nxt  = 1'b0;
        chk_err_nxt  = 1'b0;
        ovr_nxt      = 1'b0;
        wr_en        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_done && bus.rx_data == HDR_BYTE) state_nxt = LEN;
            end
            LEN: begin
                if (bus.rx_done) begin
                    if (bus.rx_data == 8'd0 || {1'b0, bus.rx_data} > MAX_LEN_W) begin
                        len_err_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        len_nxt      = bus.rx_data;
                        chk_nxt      = bus.rx_data;
                        byte_cnt_nxt = 8'd0;
                        state_nxt    = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.rx_done) begin
                    wr_en        = 1'b1;
                    chk_nxt      = chk ^ bus.rx_data;
                    byte_cnt_nxt = byte_cnt + 8'd1;
                    if (byte_cnt == len_q - 8'd1) state_nxt = CHK;
                end
            end
            CHK: begin
                if (bus.rx_done) begin
                    if (bus.rx_data == chk) begin
                        state_nxt = HOLD;
                    end else begin
                        chk_err_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            HOLD: begin
                // A byte arriving with the ack is treated as the first IDLE byte.
                if (bus.frame_ack) begin
                    state_nxt = (bus.rx_done && bus.rx_data == HDR_BYTE) ? LEN : IDLE;
                end else if (bus.rx_done) begin
                    ovr_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef UART_FRAME_TIMEOUT_EN
        if (tmo_hit) state_nxt = IDLE;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            byte_cnt        <= 8'd0;
            chk             <= 8'd0;
            len_q           <= 8'd0;
            bus.rd_data     <= 8'd0;
            bus.len_err     <= 1'b0;
            bus.chk_err     <= 1'b0;
            bus.overrun_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            byte_cnt        <= byte_cnt_nxt;
            chk             <= chk_nxt;
            len_q           <= len_nxt;
            bus.rd_data     <= buffer[bus.rd_addr];
            bus.len_err     <= len_err_nxt;
            bus.chk_err     <= chk_err_nxt;
            bus.overrun_err <= ovr_nxt;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) buffer[byte_cnt[AW-1:0]] <= bus.rx_data;
    end

    assign bus.frame_ready = (state == HOLD);
    assign bus.frame_len   = len_q;
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: per-byte status scoreboard plus buffer readback.
module tb_uart_frame_ctrl;
    localparam int MAX_LEN = 16;
    localparam int TC      = 50;
    localparam logic [4:0] RDY = 5'b00001, LENE = 5'b00010, CHKE = 5'b00100,
                           OVR = 5'b01000, TMO = 5'b10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_ctrl_if #(.MAX_LEN(MAX_LEN)) bus();

    uart_frame_ctrl #(
        .MAX_LEN(MAX_LEN), .HDR_BYTE(8'hA5), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];
    logic [4:0] e, o;
    logic [7:0] d;

    function automatic logic [4:0] status();
        return {bus.timeout_err, bus.overrun_err, bus.chk_err, bus.len_err, bus.frame_ready};
    endfunction

    task automatic send(input logic [7:0] b, input logic ack);
        @(negedge clk);
        bus.rx_done = 1'b1; bus.rx_data = b; bus.frame_ack = ack;
        @(posedge clk); #1;
        obs_q.push_back(status());
        bus.rx_done = 1'b0; bus.frame_ack = 1'b0;
    endtask

    // Full valid frame with payload base, base+1, ...; expectations queued as driven.
    task automatic send_frame(input int len, input logic [7:0] base);
        logic [7:0] c;
        c = 8'(len);
        exp_q.push_back(5'b0); send(8'hA5, 1'b0);
        exp_q.push_back(5'b0); send(8'(len), 1'b0);
        for (int i = 0; i < len; i++) begin
            c = c ^ (base + 8'(i));
            exp_q.push_back(5'b0); send(base + 8'(i), 1'b0);
        end
        exp_q.push_back(RDY); send(c, 1'b0);
    endtask

    task automatic rd(input int a, output logic [7:0] v);
        @(negedge clk); bus.rd_addr = 4'(a);
        @(posedge clk); #1; v = bus.rd_data;
    endtask

    task automatic ack_frame();
        @(negedge clk); bus.frame_ack = 1'b1;
        @(posedge clk); #1; bus.frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.rd_addr = '0; bus.frame_ack = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if ({status(), bus.frame_len, bus.rd_data} !== 21'b0) begin
            n_fail++;
            $display("FAIL reset_state: got st=%b len=%h rd=%h, expected all zero", status(), bus.frame_len, bus.rd_data);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_good_frame();
        logic [7:0] fr [6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        logic [7:0] pl [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(i == 5 ? RDY : 5'b0); send(fr[i], 1'b0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL good_frame status: got %b expected %b", o, e); end
        end
        n_checks++;
        if (bus.frame_len !== 8'd3) begin n_fail++; $display("FAIL good_frame len: got %0d expected 3", bus.frame_len); end
        for (int i = 0; i < 3; i++) begin
            rd(i, d); n_checks++;
            if (d !== pl[i]) begin n_fail++; $display("FAIL good_frame rd[%0d]: got %h expected %h", i, d, pl[i]); end
        end
        ack_frame(); n_checks++;
        if (bus.frame_ready !== 1'b0) begin n_fail++; $display("FAIL good_frame ack: frame_ready got %b expected 0", bus.frame_ready); end
    endtask

    task automatic test_chk_err();
        logic [7:0] fr [5] = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(i == 4 ? CHKE : 5'b0); send(fr[i], 1'b0);
        end
        @(posedge clk); #1; obs_q.push_back(status()); exp_q.push_back(5'b0);
        send_frame(1, 8'h42);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL chk_err status: got %b expected %b", o, e); end
        end
        ack_frame();
    endtask

    task automatic test_len_err();
        exp_q.push_back(5'b0); send(8'hA5, 1'b0);
        exp_q.push_back(LENE); send(8'h00, 1'b0);
        exp_q.push_back(5'b0); send(8'hA5, 1'b0);
        exp_q.push_back(LENE); send(8'h11, 1'b0);
        send_frame(MAX_LEN, 8'hC0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL len_err status: got %b expected %b", o, e); end
        end
        n_checks++;
        if (bus.frame_len !== 8'd16) begin n_fail++; $display("FAIL len_max len: got %0d expected 16", bus.frame_len); end
        rd(15, d); n_checks++;
        if (d !== 8'hCF) begin n_fail++; $display("FAIL len_max rd[15]: got %h expected cf", d); end
        ack_frame();
    endtask

    task automatic test_overrun();
        send_frame(1, 8'h7E);
        exp_q.push_back(RDY | OVR); send(8'h5A, 1'b0);
        exp_q.push_back(5'b0); send(8'hA5, 1'b1);
        exp_q.push_back(5'b0); send(8'h02, 1'b0);
        exp_q.push_back(5'b0); send(8'hAB, 1'b0);
        exp_q.push_back(5'b0); send(8'hCD, 1'b0);
        while (exp_q.size() > 2) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL overrun status: got %b expected %b", o, e); end
        end
        exp_q.push_back(RDY); send(8'h02 ^ 8'hAB ^ 8'hCD, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL overrun status: got %b expected %b", o, e); end
        end
        n_checks++;
        if (bus.frame_len !== 8'd2) begin n_fail++; $display("FAIL overrun next len: got %0d expected 2", bus.frame_len); end
        rd(1, d); n_checks++;
        if (d !== 8'hCD) begin n_fail++; $display("FAIL overrun next rd[1]: got %h expected cd", d); end
        ack_frame();
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(5'b0); send(8'hA5, 1'b1);
        exp_q.push_back(5'b0); send(8'h02, 1'b1);
        exp_q.push_back(5'b0); send(8'h01, 1'b1);
        exp_q.push_back(5'b0); send(8'h02, 1'b0);
        exp_q.push_back(RDY);  send(8'h02 ^ 8'h01 ^ 8'h02, 1'b1);
        ack_frame();
        send_frame(3, 8'h30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL back_to_back status: got %b expected %b", o, e); end
        end
        rd(2, d); n_checks++;
        if (d !== 8'h32) begin n_fail++; $display("FAIL back_to_back rd[2]: got %h expected 32", d); end
        ack_frame();
    endtask

    task automatic test_timeout();
        int pulses, first_at;
        exp_q.push_back(5'b0); send(8'hA5, 1'b0);
        exp_q.push_back(5'b0); send(8'h04, 1'b0);
        exp_q.push_back(5'b0); send(8'h01, 1'b0);
        pulses = 0; first_at = -1;
        for (int i = 1; i <= TC + 10; i++) begin
            @(posedge clk); #1;
            if (bus.timeout_err) begin pulses++; if (first_at < 0) first_at = i; end
        end
`ifdef UART_FRAME_TIMEOUT_EN
        n_checks++;
        if (pulses !== 1 || first_at !== TC) begin
            n_fail++; $display("FAIL timeout pulse: got %0d pulses at cycle %0d, expected 1 at %0d", pulses, first_at, TC);
        end
        send_frame(2, 8'h55);
`else
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL timeout disabled: got %0d pulses expected 0", pulses); end
        exp_q.push_back(5'b0); send(8'h02, 1'b0);
        exp_q.push_back(5'b0); send(8'h03, 1'b0);
        exp_q.push_back(5'b0); send(8'h04, 1'b0);
        exp_q.push_back(RDY);  send(8'h04 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04, 1'b0);
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL timeout status: got %b expected %b", o, e); end
        end
        ack_frame();
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(5'b0); send(8'hA5, 1'b0);
        exp_q.push_back(5'b0); send(8'h02, 1'b0);
        exp_q.push_back(5'b0); send(8'hAA, 1'b0);
        @(negedge clk); rst_n = 1'b0; #1;
        n_checks++;
        if ({status(), bus.frame_len, bus.rd_data} !== 21'b0) begin
            n_fail++; $display("FAIL reset_mid async: got st=%b len=%h rd=%h, expected all zero", status(), bus.frame_len, bus.rd_data);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1; obs_q.push_back(status()); exp_q.push_back(5'b0);
        send_frame(2, 8'h66);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset_mid status: got %b expected %b", o, e); end
        end
        rd(0, d); n_checks++;
        if (d !== 8'h66) begin n_fail++; $display("FAIL reset_mid rd[0]: got %h expected 66", d); end
        ack_frame();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_frame();
        test_chk_err();
        test_len_err();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
